// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix multiplier front end (matrix_loader).
package matmul_pkg;

    localparam int MAX_SIZE_DEF = 10;
    localparam int DATA_W_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } matload_state_t;

    typedef logic [DATA_W_DEF-1:0] elem_t;

    function automatic int idx_w(input int max_size);
        return (max_size > 1) ? $clog2(max_size) : 1;
    endfunction

endpackage

// File: rtl/matload_idx_ctr.sv
// Row-major row/col walker over an N x N window; wraps back to [0][0] after the last element.
module matload_idx_ctr
    import matmul_pkg::*;
#(
    parameter int IW = idx_w(MAX_SIZE_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [IW-1:0] lim,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col,
    output logic          last
);

    assign last = (row == lim) && (col == lim);

    // lim is N-1, so both indices stay inside the active window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col == lim) begin
                col <= '0;
                row <= (row == lim) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Streams operand elements into A then B banks (row-major) for the matrix multiplier.
// Define MATLOAD_ZERO_FILL_EN to clear both banks on every accepted start.
module matrix_loader
    import matmul_pkg::*;
#(
    parameter int MAX_SIZE = MAX_SIZE_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       size_in,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              mats_valid,
    output logic              size_err,
    output logic [31:0]       matrix_size,
    output logic [DATA_W-1:0] A [0:MAX_SIZE-1][0:MAX_SIZE-1],
    output logic [DATA_W-1:0] B [0:MAX_SIZE-1][0:MAX_SIZE-1],
    output logic [1:0]        dbg_state
);

    localparam int IW = idx_w(MAX_SIZE);

    matload_state_t state;
    logic [IW-1:0]  lim;
    logic [IW-1:0]  row;
    logic [IW-1:0]  col;
    logic           last;
    logic           size_ok;
    logic           can_start;
    logic           start_ok;
    logic           beat;

    // Stream handshake: an element transfers on a rising edge where s_valid && s_ready.
    // s_ready depends only on the state register, never on s_valid; a producer may hold
    // s_valid with stable s_data for as long as it likes.
    assign s_ready   = (state == LOAD_A) || (state == LOAD_B);
    assign busy      = s_ready;
    assign beat      = s_valid && s_ready;
    assign dbg_state = state;

    assign size_ok   = (size_in != 32'd0) && (size_in <= 32'(MAX_SIZE));
    assign can_start = (state == IDLE) || (state == DONE);
    assign start_ok  = can_start && start && size_ok;

    matload_idx_ctr #(.IW(IW)) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .en    (beat),
        .lim   (lim),
        .row   (row),
        .col   (col),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            matrix_size <= '0;
            lim         <= '0;
            done        <= 1'b0;
            size_err    <= 1'b0;
            mats_valid  <= 1'b0;
        end else begin
            done     <= 1'b0;
            size_err <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (size_ok) begin
                            matrix_size <= size_in;
                            lim         <= IW'(size_in - 32'd1);
                            mats_valid  <= 1'b0;
                            state       <= LOAD_A;
                        end else begin
                            size_err <= 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    if (beat && last) state <= LOAD_B;
                end
                LOAD_B: begin
                    if (beat && last) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        mats_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < MAX_SIZE; r++) begin
                for (int c = 0; c < MAX_SIZE; c++) begin
                    A[r][c] <= '0;
                    B[r][c] <= '0;
                end
            end
        end else if (start_ok) begin
`ifdef MATLOAD_ZERO_FILL_EN
            for (int r = 0; r < MAX_SIZE; r++) begin
                for (int c = 0; c < MAX_SIZE; c++) begin
                    A[r][c] <= '0;
                    B[r][c] <= '0;
                end
            end
`endif
        end else if (beat) begin
            if (state == LOAD_A) A[row][col] <= s_data;
            else                 B[row][col] <= s_data;
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: table-driven loads and bad sizes plus hand-written corner sequences.
module tb_matrix_loader;
    import matmul_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] size_in;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        mats_valid;
    logic        size_err;
    logic [31:0] matrix_size;
    elem_t       a_bank [0:9][0:9];
    elem_t       b_bank [0:9][0:9];
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int n;
        int base;
        bit gaps;
        int exp_lat;
        bit chk_c;
    } load_vec_t;

    typedef struct {
        logic [31:0] size;
        logic        exp_err;
    } bad_vec_t;

    load_vec_t lv [3];
    bad_vec_t  bv [2];

    matrix_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .size_in     (size_in),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .busy        (busy),
        .done        (done),
        .mats_valid  (mats_valid),
        .size_err    (size_err),
        .matrix_size (matrix_size),
        .A           (a_bank),
        .B           (b_bank),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int count_nz(input bit skip_origin);
        int cnt = 0;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                if (skip_origin && r == 0 && c == 0) continue;
                if (a_bank[r][c] != 0) cnt++;
                if (b_bank[r][c] != 0) cnt++;
            end
        end
        return cnt;
    endfunction

    task automatic start_load(input int n);
        size_in = 32'(n);
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_state", dbg_state, 64'(LOAD_A));
        check("start_s_ready", s_ready, 1);
        check("start_msize", matrix_size, 64'(n));
    endtask

    task automatic stream(input int n, input int base, input bit gaps, output int lat);
        int total;
        int idx;
        bit took;
        total = 2 * n * n;
        idx   = 0;
        lat   = 1;
        while (done !== 1'b1 && lat < 4000) begin
            s_valid = (idx < total) && (!gaps || $urandom_range(0, 2) != 0);
            s_data  = 32'(base + idx);
            took    = s_valid && s_ready;
            @(posedge clk); #1;
            lat++;
            if (took) idx++;
        end
        s_valid = 1'b0;
        check("done_seen", done, 1);
        check("beats_taken", 64'(idx), 64'(total));
        check("s_ready_after_last", s_ready, 0);
    endtask

    task automatic bad_start(input logic [31:0] sz, input logic [1:0] exp_state,
                             input logic [31:0] exp_msize, input logic exp_mv);
        size_in = sz;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bad_size_err", size_err, 1);
        check("bad_state", dbg_state, 64'(exp_state));
        check("bad_msize", matrix_size, 64'(exp_msize));
        check("bad_mats_valid", mats_valid, 64'(exp_mv));
        @(posedge clk); #1;
        check("bad_err_pulse", size_err, 0);
    endtask

    initial begin
        int lat;
        int sum;
        int c_exp [4];

        lv[0] = '{2, 1, 1'b0, 9, 1'b1};
        lv[1] = '{3, 100, 1'b1, 0, 1'b0};
        lv[2] = '{3, 100, 1'b0, 19, 1'b0};
        bv[0] = '{32'd0, 1'b1};
        bv[1] = '{32'd11, 1'b1};
        c_exp = '{19, 22, 43, 50};

        rst_n   = 1'b0;
        start   = 1'b0;
        size_in = '0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_state", dbg_state, 64'(IDLE));
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mats_valid", mats_valid, 0);
        check("rst_size_err", size_err, 0);
        check("rst_msize", matrix_size, 0);
        check("rst_banks_nz", 64'(count_nz(1'b0)), 0);

        // Offered beats in IDLE are not consumed.
        s_valid = 1'b1;
        s_data  = 32'hDEAD;
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("idle_no_consume", a_bank[0][0], 0);

        foreach (bv[i]) bad_start(bv[i].size, IDLE, 32'd0, 1'b0);

        foreach (lv[i]) begin
            start_load(lv[i].n);
            stream(lv[i].n, lv[i].base, lv[i].gaps, lat);
            if (lv[i].exp_lat != 0) check("latency", 64'(lat), 64'(lv[i].exp_lat));
            check("done_mats_valid", mats_valid, 1);
            check("done_state", dbg_state, 64'(DONE));
            for (int r = 0; r < lv[i].n; r++) begin
                for (int c = 0; c < lv[i].n; c++) begin
                    check("a_elem", a_bank[r][c], 64'(lv[i].base + r * lv[i].n + c));
                    check("b_elem", b_bank[r][c],
                          64'(lv[i].base + lv[i].n * lv[i].n + r * lv[i].n + c));
                end
            end
            if (lv[i].chk_c) begin
                for (int r = 0; r < 2; r++) begin
                    for (int c = 0; c < 2; c++) begin
                        sum = 0;
                        for (int k = 0; k < 2; k++) sum += int'(a_bank[r][k]) * int'(b_bank[k][c]);
                        check("c_elem", 64'(sum), 64'(c_exp[r * 2 + c]));
                    end
                end
            end
            @(posedge clk); #1;
            check("done_pulse_width", done, 0);
            check("mats_valid_hold", mats_valid, 1);
            check("done_s_ready", s_ready, 0);
        end

        foreach (bv[i]) bad_start(bv[i].size, DONE, 32'd3, 1'b1);
        check("bad_keeps_bank", a_bank[2][2], 108);

        // Reload at N=1 with start issued in the done cycle.
        start_load(3);
        stream(3, 100, 1'b0, lat);
        start_load(1);
        check("reload_done_drop", done, 0);
        check("reload_mats_valid_drop", mats_valid, 0);
        stream(1, 7, 1'b0, lat);
        check("reload_latency", 64'(lat), 3);
        check("reload_msize", matrix_size, 1);
        check("reload_a00", a_bank[0][0], 7);
        check("reload_b00", b_bank[0][0], 8);
`ifdef MATLOAD_ZERO_FILL_EN
        check("reload_a22", a_bank[2][2], 0);
        check("reload_stale_nz", 64'(count_nz(1'b1)), 0);
`else
        check("reload_a22", a_bank[2][2], 108);
        check("reload_stale_nz", 64'(count_nz(1'b1)), 16);
`endif

        // Reset mid-load after 5 A beats.
        @(posedge clk); #1;
        start_load(3);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(50 + i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("midload_a00", a_bank[0][0], 50);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_state", dbg_state, 64'(IDLE));
        check("mrst_s_ready", s_ready, 0);
        check("mrst_busy", busy, 0);
        check("mrst_mats_valid", mats_valid, 0);
        check("mrst_msize", matrix_size, 0);
        check("mrst_a00", a_bank[0][0], 0);
        check("mrst_banks_nz", 64'(count_nz(1'b0)), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
